// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse_meas slice: FSM state encoding and default widths.
package pulse_meas_pkg;

    localparam int PM_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } pm_state_t;

endpackage

// File: rtl/pulse_meas_edge_sync.sv
// Two-flop synchroniser plus history flop for an asynchronous trigger line;
// emits single-cycle rise/fall strobes two clocks after the edge is sampled.
module edge_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s0, s1, s2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= sig_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;
    assign fall = ~s1 & s2;

endmodule

// File: rtl/pulse_meas.sv
// Measures high time and rising-to-rising period of an asynchronous pulse train.
// Optional period watchdog enabled by defining PULSE_MEAS_TIMEOUT_EN.
module pulse_meas
    import pulse_meas_pkg::*;
#(
    parameter int W       = PM_W_DEFAULT,
    parameter int TIMEOUT = 1000
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         sig_in,
    input  logic         clr,
    output logic         meas_valid,
    input  logic         meas_ready,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period_cnt,
    output logic         ovf,
    output logic         timeout,
    output logic         busy
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         rise, fall;
    pm_state_t    state_q, state_d;
    logic [W-1:0] hc_q, hc_d, pc_q, pc_d;
    logic         capture;
    logic         tmo_hit;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    edge_sync u_edge_sync (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .sig_in  (sig_in),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef PULSE_MEAS_TIMEOUT_EN
    localparam logic [W-1:0] TMO_LIM = W'(TIMEOUT);
    // A closing rise in the same cycle wins over the watchdog.
    assign tmo_hit = (state_q != IDLE) && (pc_q == TMO_LIM) && !((state_q == LOW) && rise);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^W'(TIMEOUT);
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        pc_d    = pc_q;
        capture = 1'b0;
        if (clr) begin
            state_d = IDLE;
            hc_d    = '0;
            pc_d    = '0;
        end else if (tmo_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    state_d = HIGH;
                    hc_d    = W'(1);
                    pc_d    = W'(1);
                end
                HIGH: begin
                    pc_d = sat_inc(pc_q);
                    if (fall) state_d = LOW;
                    else      hc_d    = sat_inc(hc_q);
                end
                LOW: if (rise) begin
                    capture = 1'b1;
                    state_d = HIGH;
                    hc_d    = W'(1);
                    pc_d    = W'(1);
                end else begin
                    pc_d = sat_inc(pc_q);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            hc_q       <= '0;
            pc_q       <= '0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            ovf        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            pc_q    <= pc_d;
            if (clr) begin
                meas_valid <= 1'b0;
                ovf        <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                // A capture may coincide with the consumer taking the old result.
                if (capture && (!meas_valid || meas_ready)) begin
                    high_cnt   <= hc_q;
                    period_cnt <= pc_q;
                    meas_valid <= 1'b1;
                end else begin
                    if (capture)                 ovf        <= 1'b1;
                    if (meas_valid && meas_ready) meas_valid <= 1'b0;
                end
                if (tmo_hit) timeout <= 1'b1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas: table of periodic patterns plus hand-written
// sequences for backpressure, clear, reset and saturation (or PULSE_MEAS_TIMEOUT_EN).
module tb_pulse_meas;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        sig_in, clr, meas_ready;
    logic        meas_valid, ovf, timeout, busy;
    logic [15:0] high_cnt, period_cnt;

    logic        sig4, clr4, ready4;
    logic        valid4, ovf4, timeout4, busy4;
    logic [3:0]  high4, period4;

    int errors = 0;
    int checks = 0;
    int ncap;
    int exp_h, exp_p;

    typedef struct {
        int h;
        int l;
        int exp_high;
        int exp_period;
    } vec_t;

    vec_t vecs[6];

    pulse_meas #(.W(16), .TIMEOUT(1000)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .sig_in(sig_in), .clr(clr),
        .meas_valid(meas_valid), .meas_ready(meas_ready),
        .high_cnt(high_cnt), .period_cnt(period_cnt),
        .ovf(ovf), .timeout(timeout), .busy(busy)
    );

    pulse_meas #(.W(4), .TIMEOUT(10)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .sig_in(sig4), .clr(clr4),
        .meas_valid(valid4), .meas_ready(ready4),
        .high_cnt(high4), .period_cnt(period4),
        .ovf(ovf4), .timeout(timeout4), .busy(busy4)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            sig_in = v;
            tick();
        end
    endtask

    task automatic step(input logic v);
        sig_in = v;
        tick();
        if (meas_valid) begin
            ncap++;
            check("tbl_high_cnt", 32'(high_cnt), 32'(exp_h));
            check("tbl_period_cnt", 32'(period_cnt), 32'(exp_p));
        end
    endtask

    task automatic prepare();
        sig_in = 1'b0;
        clr    = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int cap4;
    logic [3:0] lat_h4, lat_p4;

    task automatic drive4(input logic v, input int n);
        repeat (n) begin
            sig4 = v;
            tick();
            if (valid4) begin
                cap4++;
                lat_h4 = high4;
                lat_p4 = period4;
            end
        end
    endtask

    initial begin
        vecs[0] = '{h: 3,  l: 5, exp_high: 3,  exp_period: 8};
        vecs[1] = '{h: 1,  l: 1, exp_high: 1,  exp_period: 2};
        vecs[2] = '{h: 2,  l: 7, exp_high: 2,  exp_period: 9};
        vecs[3] = '{h: 5,  l: 1, exp_high: 5,  exp_period: 6};
        vecs[4] = '{h: 1,  l: 4, exp_high: 1,  exp_period: 5};
        vecs[5] = '{h: 10, l: 3, exp_high: 10, exp_period: 13};

        RESET_N = 1'b0; sig_in = 1'b0; clr = 1'b0; meas_ready = 1'b1;
        sig4 = 1'b0; clr4 = 1'b0; ready4 = 1'b1;
        #12;
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_high", 32'(high_cnt), 0);
        check("rst_period", 32'(period_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        RESET_N = 1'b1;

        // Continuous measurement with an always-ready consumer
        foreach (vecs[i]) begin
            prepare();
            meas_ready = 1'b1;
            exp_h = vecs[i].exp_high;
            exp_p = vecs[i].exp_period;
            ncap  = 0;
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < vecs[i].h; k++) step(1'b1);
                for (int k = 0; k < vecs[i].l; k++) step(1'b0);
            end
            for (int k = 0; k < 4; k++) step(1'b1);
            for (int k = 0; k < 4; k++) step(1'b0);
            check("tbl_captures", 32'(ncap), 2);
            check("tbl_ovf", 32'(ovf), 0);
            check("tbl_timeout", 32'(timeout), 0);
        end

        // Stalled consumer: second result dropped, first one kept
        prepare();
        meas_ready = 1'b0;
        drive(1'b1, 3); drive(1'b0, 5);
        drive(1'b1, 2); drive(1'b0, 4);
        drive(1'b1, 1); drive(1'b0, 4);
        check("stall_valid", 32'(meas_valid), 1);
        check("stall_high", 32'(high_cnt), 3);
        check("stall_period", 32'(period_cnt), 8);
        check("stall_ovf", 32'(ovf), 1);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        check("stall_accept_valid", 32'(meas_valid), 0);
        check("stall_ovf_sticky", 32'(ovf), 1);

        // clr in the same cycle as the closing rise
        drive(1'b1, 1);
        drive(1'b0, 1);
        clr = 1'b1;
        tick();
        check("clr_busy", 32'(busy), 0);
        check("clr_valid", 32'(meas_valid), 0);
        check("clr_ovf", 32'(ovf), 0);
        check("clr_high_hold", 32'(high_cnt), 3);
        check("clr_period_hold", 32'(period_cnt), 8);
        clr = 1'b0;
        tick();
        check("clr_busy_after", 32'(busy), 0);

        // Capture coinciding with the handshake
        prepare();
        meas_ready = 1'b0;
        drive(1'b1, 3); drive(1'b0, 5);
        drive(1'b1, 1); drive(1'b0, 3);
        check("hs_first_valid", 32'(meas_valid), 1);
        check("hs_first_period", 32'(period_cnt), 8);
        drive(1'b1, 2);
        meas_ready = 1'b1;
        sig_in = 1'b1;
        tick();
        check("hs_valid_kept", 32'(meas_valid), 1);
        check("hs_high_new", 32'(high_cnt), 1);
        check("hs_period_new", 32'(period_cnt), 4);
        check("hs_ovf", 32'(ovf), 0);
        tick();
        check("hs_valid_drop", 32'(meas_valid), 0);

        // Asynchronous reset while in HIGH
        drive(1'b1, 2);
        check("mid_busy", 32'(busy), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_high", 32'(high_cnt), 0);
        check("arst_period", 32'(period_cnt), 0);
        check("arst_valid", 32'(meas_valid), 0);
        check("arst_ovf", 32'(ovf), 0);
        tick();
        RESET_N = 1'b1;
        tick(); tick();
        check("rel_busy_early", 32'(busy), 0);
        tick();
        check("rel_busy_rise", 32'(busy), 1);

        cap4 = 0;
        lat_h4 = '0;
        lat_p4 = '0;
`ifdef PULSE_MEAS_TIMEOUT_EN
        // Watchdog: stuck low after a single rise
        drive4(1'b1, 1);
        sig4 = 1'b0;
        repeat (11) tick();
        check("tmo_busy_before", 32'(busy4), 1);
        check("tmo_flag_before", 32'(timeout4), 0);
        tick();
        check("tmo_flag", 32'(timeout4), 1);
        check("tmo_busy", 32'(busy4), 0);
        check("tmo_valid", 32'(valid4), 0);
`else
        // Counter saturation with a 4-bit instance
        drive4(1'b1, 20); drive4(1'b0, 2);
        drive4(1'b1, 4);  drive4(1'b0, 4);
        check("sat_captures", 32'(cap4), 1);
        check("sat_high", 32'(lat_h4), 15);
        check("sat_period", 32'(lat_p4), 15);
        check("sat_ovf", 32'(ovf4), 0);
        check("sat_timeout", 32'(timeout4), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
